// File: rtl/ga_pkg.sv
// ga_pkg: shared GA constants and types used by the response path
package ga_pkg;
    localparam int GA_MV_SIZE     = 512;
    localparam int GA_RESP_WORD_W = 32;
    localparam int GA_RESP_BEATS  = GA_MV_SIZE / GA_RESP_WORD_W;
    typedef struct packed {
        logic                  valid;
        logic                  error;
        logic                  overflow;
        logic                  underflow;
        logic [GA_MV_SIZE-1:0] data;
    } ga_resp_t;
    typedef enum logic {GA_SER_IDLE, GA_SER_SEND} ga_ser_state_e;
endpackage

// File: rtl/ga_sat_counter.sv
// ga_sat_counter: up-counter that sticks at all ones; clear beats increment
module ga_sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] cnt
);
    // clear first, otherwise count until saturated
    always_ff @(posedge clk or posedge rst)
        if (rst) cnt <= '0;
        else if (clr) cnt <= '0;
        else if (inc && !(&cnt)) cnt <= cnt + 1'b1;
endmodule

// File: rtl/ga_resp_serializer.sv
// ga_resp_serializer: streams a GA response as MSW-first beats with flags on the last beat
module ga_resp_serializer import ga_pkg::*; #(
    parameter int WORD_W  = GA_RESP_WORD_W,
    parameter int MV_BITS = GA_MV_SIZE
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  ga_resp_t          resp_i,
    input  logic [4:0]        len_i,
    output logic              resp_ready_o,
    output logic [WORD_W-1:0] word_o,
    output logic              word_valid_o,
    input  logic              word_ready_i,
    output logic [3:0]        word_idx_o,
    output logic              word_last_o,
    output logic [2:0]        flags_o,
    output logic              busy_o,
    input  logic              stall_clr_i,
    output logic [31:0]       stall_cnt_o
);
    localparam int BEATS = MV_BITS / WORD_W;
    ga_ser_state_e     state, state_n;
    logic [WORD_W-1:0] beats_q [BEATS];
    logic [3:0]        idx, len_m1, len_m1_d;
    logic [2:0]        flags_q;
    logic              accept, beat_done;
    assign word_valid_o = state == GA_SER_SEND;
    assign busy_o       = word_valid_o;
    assign word_last_o  = word_valid_o && idx == len_m1;
    assign resp_ready_o = !word_valid_o || (word_last_o && word_ready_i);
    assign accept       = resp_i.valid && resp_ready_o;
    assign beat_done    = word_valid_o && word_ready_i;
    assign word_o       = word_valid_o ? beats_q[idx] : '0;
    assign word_idx_o   = idx;
    assign flags_o      = word_last_o ? flags_q : 3'b0;
    assign len_m1_d     = resp_i.error ? 4'd0 :
                          (len_i == 5'd0 || len_i > 5'(BEATS)) ? 4'(BEATS - 1) : 4'(len_i - 5'd1);
    // state register
    always_ff @(posedge clk_i or posedge rst_i)
        if (rst_i) state <= GA_SER_IDLE;
        else state <= state_n;
    // an accept always (re)starts SEND; finishing the last beat without one returns to IDLE
    always_comb begin
        state_n = state;
        if (accept) state_n = GA_SER_SEND;
        else if (beat_done && word_last_o) state_n = GA_SER_IDLE;
    end
    // capture the response split into beats (zeroed on error), and step the beat index
    always_ff @(posedge clk_i or posedge rst_i)
        if (rst_i) begin
            for (int k = 0; k < BEATS; k++) beats_q[k] <= '0;
            len_m1  <= '0;
            flags_q <= '0;
            idx     <= '0;
        end else if (accept) begin
            for (int k = 0; k < BEATS; k++)
                beats_q[k] <= resp_i.error ? '0 : resp_i.data[MV_BITS-1-k*WORD_W -: WORD_W];
            len_m1  <= len_m1_d;
            flags_q <= {resp_i.error, resp_i.overflow, resp_i.underflow};
            idx     <= '0;
        end else if (beat_done) begin
            idx <= word_last_o ? 4'd0 : idx + 4'd1;
        end
    ga_sat_counter #(.WIDTH(32)) u_stall (
        .clk (clk_i),
        .rst (rst_i),
        .inc (word_valid_o && !word_ready_i),
        .clr (stall_clr_i),
        .cnt (stall_cnt_o)
    );
endmodule

// File: tb/tb_ga_resp_serializer.sv
// tb_ga_resp_serializer: vector table, directed corner cases and a queue-model random run
module tb_ga_resp_serializer;
    import ga_pkg::*;
    typedef struct {
        logic        err, ovf, udf;
        logic [4:0]  len;
        logic [31:0] top;
        int          beats;
        logic [31:0] w0;
        logic [2:0]  fl;
    } vec_t;
    typedef struct {
        logic [31:0] word;
        logic [3:0]  idx;
        logic        last;
        logic [2:0]  flags;
    } beat_t;
    logic clk = 0, rst = 0;
    ga_resp_t resp = '0;
    logic [4:0] len = '0;
    logic resp_ready, word_valid, word_ready = 0, word_last, busy, stall_clr = 0;
    logic [31:0] word, stall_cnt;
    logic [3:0] idx;
    logic [2:0] flags;
    logic sc_inc = 0, sc_clr = 0;
    logic [3:0] sc_cnt;
    int checks = 0, errors = 0;
    vec_t vecs[6];
    beat_t q[$];
    beat_t b;
    logic [511:0] d, d2;
    int n, cur, L, stall_m;
    int pat[7] = '{1, 0, 0, 1, 1, 0, 1};
    logic exp_v, exp_rr;

    always #5 clk = ~clk;

    ga_resp_serializer dut (
        .clk_i(clk), .rst_i(rst), .resp_i(resp), .len_i(len), .resp_ready_o(resp_ready),
        .word_o(word), .word_valid_o(word_valid), .word_ready_i(word_ready), .word_idx_o(idx),
        .word_last_o(word_last), .flags_o(flags), .busy_o(busy), .stall_clr_i(stall_clr),
        .stall_cnt_o(stall_cnt)
    );

    ga_sat_counter #(.WIDTH(4)) u_sc (.clk(clk), .rst(rst), .inc(sc_inc), .clr(sc_clr), .cnt(sc_cnt));

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] beat_of(input logic [511:0] dd, input int k);
        return dd[511-32*k -: 32];
    endfunction

    function automatic logic [511:0] mk_full();
        logic [511:0] r;
        for (int k = 0; k < 16; k++) r[511-32*k -: 32] = {16'(2*k+1), 16'(2*k+2)};
        return r;
    endfunction

    task automatic set_resp(input logic [511:0] dd, input logic e, input logic o, input logic u, input logic [4:0] l);
        resp.valid = 1; resp.error = e; resp.overflow = o; resp.underflow = u; resp.data = dd; len = l;
    endtask

    task automatic present(input logic [511:0] dd, input logic e, input logic o, input logic u, input logic [4:0] l);
        set_resp(dd, e, o, u, l);
        #1;
        chk("accept_ready", resp_ready, 1);
        next_cycle();
        resp.valid = 0;
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_resp_ready"}, resp_ready, 1);
        chk({tag, "_word_valid"}, word_valid, 0);
        chk({tag, "_word"}, word, 0);
        chk({tag, "_idx"}, idx, 0);
        chk({tag, "_last"}, word_last, 0);
        chk({tag, "_flags"}, flags, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_stall"}, stall_cnt, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{1'b0, 1'b1, 1'b0, 5'd1, 32'h7FFF_1234, 1, 32'h7FFF_1234, 3'b010};
        vecs[1] = '{1'b1, 1'b0, 1'b0, 5'd8, 32'hDEAD_BEEF, 1, 32'h0, 3'b100};
        vecs[2] = '{1'b0, 1'b0, 1'b1, 5'd3, 32'h1111_2222, 3, 32'h1111_2222, 3'b001};
        vecs[3] = '{1'b0, 1'b1, 1'b1, 5'd0, 32'hA5A5_5A5A, 16, 32'hA5A5_5A5A, 3'b011};
        vecs[4] = '{1'b1, 1'b1, 1'b1, 5'd0, 32'hFFFF_FFFF, 1, 32'h0, 3'b111};
        vecs[5] = '{1'b0, 1'b0, 1'b0, 5'd16, 32'h0BAD_F00D, 16, 32'h0BAD_F00D, 3'b000};

        #1 rst = 1;
        #1 check_reset_values("reset");
        next_cycle();
        rst = 0;

        // full 16-beat result, ready held high
        d = mk_full();
        word_ready = 1;
        present(d, 0, 0, 0, 5'd0);
        for (int k = 0; k < 16; k++) begin
            #1;
            chk("full_valid", word_valid, 1);
            chk("full_word", word, beat_of(d, k));
            chk("full_idx", idx, k);
            chk("full_last", word_last, k == 15);
            next_cycle();
        end
        #1 chk("full_done", word_valid, 0);
        chk("full_beat0", beat_of(d, 0), 32'h0001_0002);

        // vector table of single transactions
        for (int i = 0; i < 6; i++) begin
            next_cycle();
            word_ready = 1;
            d = {vecs[i].top, {15{32'hCCCC_3333}}};
            present(d, vecs[i].err, vecs[i].ovf, vecs[i].udf, vecs[i].len);
            n = 0;
            for (int c = 0; c < 20 && n < vecs[i].beats; c++) begin
                #1;
                if (word_valid) begin
                    if (n == 0) chk("vec_word0", word, vecs[i].w0);
                    chk("vec_idx", idx, n);
                    chk("vec_last", word_last, n == vecs[i].beats - 1);
                    chk("vec_flags", flags, (n == vecs[i].beats - 1) ? vecs[i].fl : 3'b0);
                    n++;
                end
                next_cycle();
            end
            chk("vec_beats", n, vecs[i].beats);
            #1 chk("vec_idle", {word_valid, resp_ready}, 2'b01);
        end

        // backpressure with ready pattern 1,0,0,1,1,0,1
        stall_clr = 1;
        next_cycle();
        stall_clr = 0;
        d = mk_full();
        word_ready = 1;
        present(d, 0, 0, 0, 5'd4);
        cur = 0;
        for (int i = 0; i < 7; i++) begin
            word_ready = pat[i][0];
            #1;
            chk("bp_valid", word_valid, 1);
            chk("bp_idx", idx, cur);
            chk("bp_word", word, beat_of(d, cur));
            chk("bp_last", word_last, cur == 3);
            if (pat[i] != 0) cur++;
            next_cycle();
        end
        #1;
        chk("bp_done", word_valid, 0);
        chk("bp_stalls", stall_cnt, 3);

        // back-to-back: second response accepted on the first one's last beat
        next_cycle();
        word_ready = 1;
        d = mk_full();
        d2 = ~mk_full();
        present(d, 0, 0, 0, 5'd2);
        #1 chk("b2b_idx0", idx, 0);
        next_cycle();
        set_resp(d2, 0, 0, 1, 5'd3);
        #1;
        chk("b2b_last", word_last, 1);
        chk("b2b_ready", resp_ready, 1);
        next_cycle();
        resp.valid = 0;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("b2b_valid", word_valid, 1);
            chk("b2b_idx", idx, k);
            chk("b2b_word", word, beat_of(d2, k));
            chk("b2b_flags", flags, k == 2 ? 3'b001 : 3'b000);
            next_cycle();
        end
        #1 chk("b2b_done", word_valid, 0);

        // reset in the middle of a 16-beat transfer
        present(d, 0, 0, 0, 5'd0);
        word_ready = 0;
        next_cycle();
        word_ready = 1;
        for (int k = 0; k < 7; k++) next_cycle();
        #1;
        chk("mid_idx", idx, 7);
        chk("mid_stall", stall_cnt, 4);
        #2 rst = 1;
        #1 check_reset_values("mid_reset");
        next_cycle();
        rst = 0;
        present(d2, 0, 0, 0, 5'd2);
        #1;
        chk("post_idx", idx, 0);
        chk("post_word", word, beat_of(d2, 0));
        chk("post_valid", word_valid, 1);
        next_cycle();
        next_cycle();
        #1 chk("post_done", word_valid, 0);

        // clear together with a stall gives zero
        word_ready = 1;
        present(d, 0, 0, 0, 5'd4);
        word_ready = 0;
        next_cycle();
        next_cycle();
        #1 chk("clr_pre", stall_cnt, 2);
        stall_clr = 1;
        next_cycle();
        stall_clr = 0;
        #1 chk("clr_with_stall", stall_cnt, 0);
        next_cycle();
        #1 chk("clr_then_stall", stall_cnt, 1);
        word_ready = 1;
        for (int k = 0; k < 4; k++) next_cycle();
        #1 chk("clr_done", word_valid, 0);

        // saturation on a narrow instance of the same counter
        sc_inc = 1;
        for (int k = 0; k < 14; k++) next_cycle();
        #1 chk("sat_count", sc_cnt, 14);
        for (int k = 0; k < 6; k++) next_cycle();
        #1 chk("sat_hold", sc_cnt, 15);
        sc_clr = 1;
        next_cycle();
        #1 chk("sat_clr_wins", sc_cnt, 0);
        sc_clr = 0;
        next_cycle();
        #1 chk("sat_restart", sc_cnt, 1);
        sc_inc = 0;

        // random traffic against a queue of expected beats
        rst = 1;
        next_cycle();
        rst = 0;
        stall_m = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            resp.valid = $urandom_range(0, 2) == 0;
            resp.error = $urandom_range(0, 7) == 0;
            resp.overflow = 1'($urandom());
            resp.underflow = 1'($urandom());
            for (int w = 0; w < 16; w++) resp.data[32*w +: 32] = $urandom();
            len = 5'($urandom_range(0, 16));
            word_ready = $urandom_range(0, 3) != 0;
            stall_clr = $urandom_range(0, 31) == 0;
            #1;
            exp_v = q.size() != 0;
            exp_rr = !exp_v || (q.size() == 1 && word_ready);
            chk("rnd_valid", word_valid, exp_v);
            chk("rnd_busy", busy, exp_v);
            chk("rnd_ready", resp_ready, exp_rr);
            chk("rnd_stall", stall_cnt, stall_m);
            if (exp_v) begin
                chk("rnd_word", word, q[0].word);
                chk("rnd_idx", idx, q[0].idx);
                chk("rnd_last", word_last, q[0].last);
                chk("rnd_flags", flags, q[0].flags);
            end
            if (stall_clr) stall_m = 0;
            else if (exp_v && !word_ready) stall_m++;
            if (exp_v && word_ready) void'(q.pop_front());
            if (resp.valid && exp_rr) begin
                L = resp.error ? 1 : (len == 0 ? 16 : int'(len));
                for (int k = 0; k < L; k++) begin
                    b.word = resp.error ? 32'h0 : beat_of(resp.data, k);
                    b.idx = 4'(k);
                    b.last = k == L - 1;
                    b.flags = (k == L - 1) ? {resp.error, resp.overflow, resp.underflow} : 3'b0;
                    q.push_back(b);
                end
            end
            next_cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
